// File: rtl/imem_loader_defs.sv
// imem_loader_defs: shared definitions for the instruction-memory boot loader.
// Holds the FSM state encoding, frame layout constants and default geometry.
// The testbench imports the same package.
package imem_loader_defs;

   localparam int DEF_ADDR_W     = 10;  // 1024-word instruction memory
   localparam int DEF_DATA_W     = 16;  // one instruction = two bytes
   localparam int HDR_BYTES      = 2;   // LEN_HI, LEN_LO
   localparam int BYTES_PER_WORD = 2;   // HI, LO

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LEN_HI  = 3'd1,
      S_LEN_LO  = 3'd2,
      S_DATA_HI = 3'd3,
      S_DATA_LO = 3'd4,
      S_CHECK   = 3'd5,
      S_DONE    = 3'd6,
      S_ERR     = 3'd7
   } state_e;

endpackage

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the processor instruction memory.
// Receives a framed byte stream (LEN_HI, LEN_LO, N x {HI, LO}, CHK) over a
// valid/ready handshake, writes the assembled words to addresses 0..N-1 and
// keeps the core in reset until a load finishes with a matching XOR checksum.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 pulse; begins a load from IDLE, DONE or ERR
//   in_valid/in_data      byte stream input; in_ready = loader accepts a byte
//   mem_we/addr/wdata     registered instruction-memory write port
//   core_hold             1 = processor held in reset (low only in DONE)
//   busy                  load in progress
//   done / error          level status of the last load
//   words_loaded          words written in the current/last load
module imem_loader
   import imem_loader_defs::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              core_hold,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam logic [16:0] MAX_LEN = 17'(2**ADDR_W);

   state_e              state_q, state_d;
   logic [7:0]          len_hi_q, len_hi_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic [7:0]          hi_q, hi_d;
   logic [7:0]          acc_q, acc_d;
   logic [ADDR_W:0]     words_q, words_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

   logic                accept;
   logic [15:0]         len_word;
   logic [ADDR_W:0]     words_inc;

   assign busy      = state_q inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK};
   assign in_ready  = busy;
   assign accept    = in_valid && busy;
   assign done      = (state_q == S_DONE);
   assign error     = (state_q == S_ERR);
   assign core_hold = (state_q != S_DONE);

   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign words_loaded = words_q;

   always_comb begin
      state_d     = state_q;
      len_hi_d    = len_hi_q;
      len_d       = len_q;
      hi_d        = hi_q;
      acc_d       = acc_q;
      words_d     = words_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      len_word    = {len_hi_q, in_data};
      words_inc   = words_q + 1'b1;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_LEN_HI;
               words_d = '0;
               acc_d   = '0;
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               len_hi_d = in_data;
               state_d  = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               if (len_word == 16'd0 || {1'b0, len_word} > MAX_LEN) begin
                  state_d = S_ERR;
               end else begin
                  len_d   = len_word[ADDR_W:0];
                  state_d = S_DATA_HI;
               end
            end
         end
         S_DATA_HI: begin
            if (accept) begin
               hi_d    = in_data;
               acc_d   = acc_q ^ in_data;
               state_d = S_DATA_LO;
            end
         end
         S_DATA_LO: begin
            if (accept) begin
               // The write address always equals the count of words already
               // written, so words_q doubles as the address counter; it is
               // below N <= 2^ADDR_W here, so the low bits never wrap.
               mem_we_d    = 1'b1;
               mem_addr_d  = words_q[ADDR_W-1:0];
               mem_wdata_d = DATA_W'({hi_q, in_data});
               acc_d       = acc_q ^ in_data;
               words_d     = words_inc;
               state_d     = (words_inc == len_q) ? S_CHECK : S_DATA_HI;
            end
         end
         S_CHECK: begin
            if (accept) begin
               state_d = (in_data == acc_q) ? S_DONE : S_ERR;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         len_hi_q    <= '0;
         len_q       <= '0;
         hi_q        <= '0;
         acc_q       <= '0;
         words_q     <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         len_hi_q    <= len_hi_d;
         len_q       <= len_d;
         hi_q        <= hi_d;
         acc_q       <= acc_d;
         words_q     <= words_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader. Frames are built as
// byte queues; expected writes and outcome are derived from the frame rules.
module tb_imem_loader;
   import imem_loader_defs::*;

   localparam int AW    = DEF_ADDR_W;
   localparam int DW    = DEF_DATA_W;
   localparam int DEPTH = 1 << AW;

   logic          clk;
   logic          reset_n;
   logic          start;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          core_hold;
   logic          busy;
   logic          done;
   logic          error;
   logic [AW:0]   words_loaded;

   imem_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .core_hold(core_hold), .busy(busy), .done(done), .error(error),
      .words_loaded(words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]    frame[$];
   logic [AW-1:0] wr_addr[$];
   logic [DW-1:0] wr_data[$];
   logic [AW:0]   wr_wl[$];
   logic [AW-1:0] prev_addr;
   logic [DW-1:0] prev_data;
   int            hold_viol = 0;

   // Write-port monitor: records every write and notes if addr/data move
   // while mem_we is low.
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_addr = '0;
         prev_data = '0;
      end else begin
         if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            wr_wl.push_back(words_loaded);
         end else if (mem_addr !== prev_addr || mem_wdata !== prev_data) begin
            hold_viol++;
         end
         prev_addr = mem_addr;
         prev_data = mem_wdata;
      end
   end

   task automatic build_nominal(input logic [7:0] chk);
      frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, chk};
   endtask

   // Drives the current frame (after a start pulse) and compares the result
   // against what the frame rules predict.
   task automatic run_frame(input string name, input int idle_pct,
                            input bit mid_start, input bit start_valid);
      int         n;
      bit         len_ok;
      bit         exp_done;
      int         exp_writes;
      logic [7:0] chk;
      logic [DW-1:0] exp_word;
      bit         rdy;
      int         budget;

      n          = {frame[0], frame[1]};
      len_ok     = (n != 0) && (n <= DEPTH);
      exp_writes = len_ok ? n : 0;
      exp_done   = 1'b0;
      if (len_ok) begin
         chk = 8'h00;
         for (int i = 0; i < BYTES_PER_WORD * n; i++) chk ^= frame[HDR_BYTES + i];
         exp_done = (frame[HDR_BYTES + BYTES_PER_WORD * n] == chk);
      end

      wr_addr.delete(); wr_data.delete(); wr_wl.delete();

      start = 1'b1; in_valid = start_valid; in_data = 8'hFF;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b0;

      n_checks++;
      if ({busy, in_ready, done, error, core_hold} !== 5'b11001 || words_loaded !== '0)
         $display("FAIL %s start: busy/rdy/done/err/hold=%b wl=%0d, expected 11001 wl=0",
                  name, {busy, in_ready, done, error, core_hold}, words_loaded);
         else n_checks = n_checks;
      if ({busy, in_ready, done, error, core_hold} !== 5'b11001 || words_loaded !== '0) n_fail++;

      for (int i = 0; i < frame.size(); i++) begin
         while ($urandom_range(99) < idle_pct) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = frame[i];
         if (mid_start && i == 3) start = 1'b1;
         budget = 0;
         do begin
            rdy = in_ready;
            @(posedge clk); #1;
            budget++;
         end while (!rdy && budget < 100);
         start    = 1'b0;
         in_valid = 1'b0;
         n_checks++;
         if (!rdy) begin
            n_fail++;
            $display("FAIL %s handshake: byte %0d not accepted in 100 cycles, expected acceptance", name, i);
            return;
         end
      end

      n_checks++;
      if (done !== exp_done || error !== !exp_done) begin
         n_fail++;
         $display("FAIL %s status: done=%b error=%b, expected done=%b error=%b",
                  name, done, error, exp_done, !exp_done);
      end
      n_checks++;
      if (core_hold !== !exp_done || busy !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s hold/busy/rdy: %b%b%b, expected %b00",
                  name, core_hold, busy, in_ready, !exp_done);
      end
      n_checks++;
      if (words_loaded !== (AW+1)'(exp_writes)) begin
         n_fail++;
         $display("FAIL %s words_loaded: got %0d, expected %0d", name, words_loaded, exp_writes);
      end
      n_checks++;
      if (wr_addr.size() !== exp_writes) begin
         n_fail++;
         $display("FAIL %s write count: got %0d, expected %0d", name, wr_addr.size(), exp_writes);
      end else begin
         for (int i = 0; i < exp_writes; i++) begin
            exp_word = {frame[HDR_BYTES + 2*i], frame[HDR_BYTES + 2*i + 1]};
            n_checks++;
            if (wr_addr[i] !== AW'(i) || wr_data[i] !== exp_word || wr_wl[i] !== (AW+1)'(i + 1)) begin
               n_fail++;
               $display("FAIL %s write %0d: addr=%h data=%h wl=%0d, expected addr=%h data=%h wl=%0d",
                        name, i, wr_addr[i], wr_data[i], wr_wl[i], i, exp_word, i + 1);
            end
         end
      end

      // Outcome is a level and no stray write follows it.
      @(posedge clk); #1;
      n_checks++;
      if (done !== exp_done || error !== !exp_done || wr_addr.size() !== exp_writes) begin
         n_fail++;
         $display("FAIL %s settle: done=%b error=%b writes=%0d, expected %b %b %0d",
                  name, done, error, wr_addr.size(), exp_done, !exp_done, exp_writes);
      end
      n_checks++;
      if (hold_viol !== 0) begin
         n_fail++;
         $display("FAIL %s addr/data hold: %0d changes while mem_we=0, expected 0", name, hold_viol);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      #12;
      n_checks++;
      if ({core_hold, busy, in_ready, done, error, mem_we} !== 6'b100000 ||
          mem_addr !== '0 || mem_wdata !== '0 || words_loaded !== '0) begin
         n_fail++;
         $display("FAIL reset: hold/busy/rdy/done/err/we=%b addr=%h data=%h wl=%0d, expected 100000 0 0 0",
                  {core_hold, busy, in_ready, done, error, mem_we}, mem_addr, mem_wdata, words_loaded);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({core_hold, busy, in_ready, done, error, mem_we} !== 6'b100000) begin
         n_fail++;
         $display("FAIL idle: hold/busy/rdy/done/err/we=%b, expected 100000",
                  {core_hold, busy, in_ready, done, error, mem_we});
      end
   endtask

   task automatic test_nominal();
      build_nominal(8'h40);
      run_frame("nominal", 0, 1'b0, 1'b0);
   endtask

   task automatic test_bad_checksum();
      build_nominal(8'h41);
      run_frame("bad_checksum", 0, 1'b0, 1'b0);
   endtask

   task automatic test_bad_length();
      frame = '{8'h00, 8'h00};
      run_frame("len_zero", 0, 1'b0, 1'b0);
      frame = '{8'h04, 8'h01};
      run_frame("len_1025", 0, 1'b0, 1'b0);
   endtask

   task automatic test_backpressure();
      build_nominal(8'h40);
      run_frame("backpressure", 60, 1'b1, 1'b0);
   endtask

   task automatic test_start_with_valid();
      build_nominal(8'h40);
      run_frame("start_with_valid", 0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_midload();
      logic [7:0] hdr[4];
      bit         rdy;
      int         budget;
      hdr = '{8'h00, 8'h02, 8'h12, 8'h34};
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = hdr[i];
         budget   = 0;
         do begin
            rdy = in_ready;
            @(posedge clk); #1;
            budget++;
         end while (!rdy && budget < 100);
         in_valid = 1'b0;
      end
      n_checks++;
      if (mem_we !== 1'b1 || mem_wdata !== 16'h1234 || words_loaded !== 1) begin
         n_fail++;
         $display("FAIL midload write: we=%b data=%h wl=%0d, expected 1 1234 1", mem_we, mem_wdata, words_loaded);
      end
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({core_hold, busy, in_ready, done, error, mem_we} !== 6'b100000 ||
          mem_addr !== '0 || mem_wdata !== '0 || words_loaded !== '0) begin
         n_fail++;
         $display("FAIL midload reset: hold/busy/rdy/done/err/we=%b addr=%h data=%h wl=%0d, expected 100000 0 0 0",
                  {core_hold, busy, in_ready, done, error, mem_we}, mem_addr, mem_wdata, words_loaded);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      build_nominal(8'h40);
      run_frame("after_reset", 0, 1'b0, 1'b0);
   endtask

   task automatic test_full_depth();
      logic [7:0] chk;
      logic [15:0] w;
      frame.delete();
      frame.push_back(8'h04);
      frame.push_back(8'h00);
      chk = 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
         w = 16'(i);
         frame.push_back(w[15:8]);
         frame.push_back(w[7:0]);
         chk ^= w[15:8] ^ w[7:0];
      end
      frame.push_back(chk);
      run_frame("full_depth", 0, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      int         n;
      logic [7:0] chk;
      logic [7:0] b;
      for (int k = 0; k < 6; k++) begin
         n = $urandom_range(1, 12);
         frame.delete();
         frame.push_back(8'h00);
         frame.push_back(8'(n));
         chk = 8'h00;
         for (int i = 0; i < 2 * n; i++) begin
            b = 8'($urandom);
            frame.push_back(b);
            chk ^= b;
         end
         if ($urandom_range(1) == 1) chk ^= 8'(1 << $urandom_range(7));
         frame.push_back(chk);
         run_frame("random", $urandom_range(50), 1'b0, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_bad_checksum();
      test_bad_length();
      test_backpressure();
      test_start_with_valid();
      test_reset_midload();
      test_full_depth();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the processor's 1024×16 instruction memory. It accepts a framed byte stream over a valid/ready handshake, assembles 16-bit instruction words and writes them to consecutive instruction-memory addresses starting at 0. It holds the processor core in reset until a load completes with a correct checksum. It sits between the host/debug byte link and the instruction memory's write port, opposite the core's fetch (read) side.

## Interface
- ADDR_W, 10, instruction-memory address width (depth 2^ADDR_W words)
- DATA_W, 16, instruction word width (fixed at two bytes)
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
- in_valid  in  1  byte stream valid
- in_data  in  8  byte stream data
- in_ready  out  1  loader accepts a byte; a byte transfers when in_valid && in_ready
- mem_we  out  1  instruction-memory write strobe, one cycle per word
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  DATA_W  write data
- core_hold  out  1  1 = processor held in reset
- busy  out  1  load in progress
- done  out  1  level; last load succeeded
- error  out  1  level; last load failed
- words_loaded  out  ADDR_W+1  words written in current/last load

## Operation
- Frame format:
  - LEN_HI, LEN_LO: big-endian word count N.
  - N × (HI byte, LO byte): instruction = {HI, LO}.
  - CHK: XOR of all 2N payload bytes. Header bytes are excluded.
- States: IDLE → LEN_HI → LEN_LO → DATA_HI ↔ DATA_LO → CHECK → DONE | ERR.
- IDLE/DONE/ERR + start → LEN_HI. This clears words_loaded, the address counter, the checksum accumulator, done and error.
- start in any other state is ignored.
- LEN_LO accept:
  - N == 0 or N > 2^ADDR_W → ERR. No writes occur.
  - Otherwise store N → DATA_HI.
- DATA_HI accept: latch the high byte → DATA_LO.
- DATA_LO accept:
  - Issue a write of {hi, byte} at the address counter.
  - Increment the address and words_loaded.
  - If words_loaded+1 == N → CHECK, else → DATA_HI.
- CHECK accept: byte == accumulator → DONE, else → ERR.
- Checksum accumulator XORs every accepted DATA_HI/DATA_LO byte.
- Written words are never rolled back on ERR.
- core_hold is 1 in every state except DONE.
- busy is 1 in LEN_HI through CHECK.
- in_ready is 1 exactly when busy.
- Address arithmetic is ADDR_W bits and never wraps: N ≤ 2^ADDR_W guarantees the last address is ≤ 2^ADDR_W−1.

## Timing
- Reset values (asynchronous assert): state=IDLE, core_hold=1, busy=0, in_ready=0, done=0, error=0, mem_we=0, mem_addr=0, mem_wdata=0, words_loaded=0, accumulator=0.
- in_ready is decoded from the registered state only; it has no combinational path from in_valid.
- Throughput: one byte per cycle when in_valid is held high.
- Handshake stalls (in_valid=0) hold all state.
- mem_we, mem_addr and mem_wdata are registered. The write appears the cycle after the DATA_LO handshake; mem_we is high for exactly one cycle.
- mem_addr and mem_wdata hold their values when mem_we=0.
- done/error assert the cycle after the CHECK (or failing LEN_LO) handshake.
- core_hold deasserts in that same cycle as done. By then the final mem_we has already been issued, at least one cycle earlier.
- words_loaded updates in the same cycle as the corresponding mem_we.
- Reset mid-load: everything returns to reset values immediately. Words already written remain in memory.
- start coincident with in_valid in IDLE: only start takes effect. The byte is not accepted because in_ready=0 that cycle.

## Structure
- Shared package/header `imem_loader_defs`: state encodings (3-bit), frame constants (header byte count 2, bytes per word 2), default ADDR_W/DATA_W. The same header is used by the testbench.
- Single module, no sub-module. The FSM, address/word counters, hi-byte latch and XOR accumulator are all local registers.

## Test plan
- Nominal load: start, bytes 00 02 12 34 AB CD 40 →
  - writes addr0=0x1234 and addr1=0xABCD;
  - done=1, error=0, core_hold=0, words_loaded=2.
- Bad checksum: same stream, last byte 41 →
  - both writes still occur;
  - error=1, done=0, core_hold=1.
- Bad length:
  - header 00 00 → error=1 after the second byte, no mem_we;
  - header 04 01 → error=1, no mem_we.
- Backpressure: nominal stream with in_valid toggled randomly (≥50% idle) → identical writes and final state to the nominal load.
- Reset mid-load: assert reset_n=0 after the first word is written →
  - IDLE with all reset values;
  - a subsequent start + nominal stream succeeds.
- Full depth: N=1024 (04 00), word i = i, correct checksum →
  - last write at addr 0x3FF;
  - words_loaded=1024, done=1, no address wrap.
